// File: rtl/operand_fetch_buffer.sv
// Decode-to-execute operand fetch stage: two-entry skid buffer (head H, skid S)
// with optional EX/MEM result forwarding enabled by the OPERAND_FWD_EN macro.
module operand_fetch_buffer #(
    parameter int DW   = 32,
    parameter int IMMW = 22
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [DW-1:0]   in_rs1_val,
    input  logic [DW-1:0]   in_rs2_val,
    input  logic            fwd_ex_valid,
    input  logic [4:0]      fwd_ex_rd,
    input  logic [DW-1:0]   fwd_ex_val,
    input  logic            fwd_mem_valid,
    input  logic [4:0]      fwd_mem_rd,
    input  logic [DW-1:0]   fwd_mem_val,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_is,
    output logic [DW-1:0]   out_r,
    output logic [DW-1:0]   out_rs1,
    output logic [IMMW-1:0] out_imm
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [31:0]   h_inst_q, h_inst_d, s_inst_q, s_inst_d;
    logic [DW-1:0] h_rs1_q, h_rs1_d, s_rs1_q, s_rs1_d;
    logic [DW-1:0] h_rs2_q, h_rs2_d, s_rs2_q, s_rs2_d;

    // Operand values after forwarding: held entries and the incoming capture.
    logic [DW-1:0] h_rs1_f, h_rs2_f, s_rs1_f, s_rs2_f;
    logic [DW-1:0] in_rs1_f, in_rs2_f;

    logic acc, pop;

`ifdef OPERAND_FWD_EN
    function automatic logic [DW-1:0] fwd_sel(
        input logic [4:0]    idx,
        input logic [DW-1:0] v,
        input logic          exv,
        input logic [4:0]    exrd,
        input logic [DW-1:0] exval,
        input logic          memv,
        input logic [4:0]    memrd,
        input logic [DW-1:0] memval
    );
        if (idx == 5'd0)
            return '0;
        else if (exv && exrd == idx)
            return exval;
        else if (memv && memrd == idx)
            return memval;
        else
            return v;
    endfunction

    assign h_rs1_f  = fwd_sel(h_inst_q[18:14], h_rs1_q, fwd_ex_valid, fwd_ex_rd, fwd_ex_val,
                              fwd_mem_valid, fwd_mem_rd, fwd_mem_val);
    assign h_rs2_f  = fwd_sel(h_inst_q[4:0], h_rs2_q, fwd_ex_valid, fwd_ex_rd, fwd_ex_val,
                              fwd_mem_valid, fwd_mem_rd, fwd_mem_val);
    assign s_rs1_f  = fwd_sel(s_inst_q[18:14], s_rs1_q, fwd_ex_valid, fwd_ex_rd, fwd_ex_val,
                              fwd_mem_valid, fwd_mem_rd, fwd_mem_val);
    assign s_rs2_f  = fwd_sel(s_inst_q[4:0], s_rs2_q, fwd_ex_valid, fwd_ex_rd, fwd_ex_val,
                              fwd_mem_valid, fwd_mem_rd, fwd_mem_val);
    assign in_rs1_f = fwd_sel(in_inst[18:14], in_rs1_val, fwd_ex_valid, fwd_ex_rd, fwd_ex_val,
                              fwd_mem_valid, fwd_mem_rd, fwd_mem_val);
    assign in_rs2_f = fwd_sel(in_inst[4:0], in_rs2_val, fwd_ex_valid, fwd_ex_rd, fwd_ex_val,
                              fwd_mem_valid, fwd_mem_rd, fwd_mem_val);
`else
    // Forwarding ports are kept for a uniform interface but have no effect.
    logic unused_fwd;
    assign unused_fwd = ^{fwd_ex_valid, fwd_ex_rd, fwd_ex_val,
                          fwd_mem_valid, fwd_mem_rd, fwd_mem_val};

    assign h_rs1_f  = h_rs1_q;
    assign h_rs2_f  = h_rs2_q;
    assign s_rs1_f  = s_rs1_q;
    assign s_rs2_f  = s_rs2_q;
    assign in_rs1_f = in_rs1_val;
    assign in_rs2_f = in_rs2_val;
`endif

    assign acc = in_valid & in_ready;
    assign pop = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: if (acc)         state_d = ST_ONE;
                ST_ONE:   if (acc && !pop) state_d = ST_TWO;
                          else if (!acc && pop) state_d = ST_EMPTY;
                ST_TWO:   if (pop)         state_d = ST_ONE;
                default:                   state_d = ST_EMPTY;
            endcase
        end
    end

    // in_ready depends on the state register alone, never on out_ready.
    always_comb begin
        in_ready  = (state_q != ST_TWO);
        out_valid = (state_q != ST_EMPTY);
    end

    always_comb begin
        h_inst_d = h_inst_q;
        h_rs1_d  = h_rs1_f;
        h_rs2_d  = h_rs2_f;
        s_inst_d = s_inst_q;
        s_rs1_d  = s_rs1_f;
        s_rs2_d  = s_rs2_f;
        case (state_q)
            ST_EMPTY: begin
                if (acc) begin
                    h_inst_d = in_inst;
                    h_rs1_d  = in_rs1_f;
                    h_rs2_d  = in_rs2_f;
                end
            end
            ST_ONE: begin
                if (acc && pop) begin
                    h_inst_d = in_inst;
                    h_rs1_d  = in_rs1_f;
                    h_rs2_d  = in_rs2_f;
                end else if (acc) begin
                    s_inst_d = in_inst;
                    s_rs1_d  = in_rs1_f;
                    s_rs2_d  = in_rs2_f;
                end
            end
            ST_TWO: begin
                if (pop) begin
                    h_inst_d = s_inst_q;
                    h_rs1_d  = s_rs1_f;
                    h_rs2_d  = s_rs2_f;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_inst_q <= '0;
            h_rs1_q  <= '0;
            h_rs2_q  <= '0;
            s_inst_q <= '0;
            s_rs1_q  <= '0;
            s_rs2_q  <= '0;
        end else begin
            h_inst_q <= h_inst_d;
            h_rs1_q  <= h_rs1_d;
            h_rs2_q  <= h_rs2_d;
            s_inst_q <= s_inst_d;
            s_rs1_q  <= s_rs1_d;
            s_rs2_q  <= s_rs2_d;
        end
    end

    assign out_is  = h_inst_q;
    assign out_r   = h_rs2_q;
    assign out_rs1 = h_rs1_q;
    assign out_imm = h_inst_q[IMMW-1:0];

endmodule

// File: tb/tb_operand_fetch_buffer.sv
// Bench for operand_fetch_buffer: directed steps then random traffic, checked
// against a queue-based model of a two-deep FIFO with operand forwarding.
module tb_operand_fetch_buffer;

    localparam int DW   = 32;
    localparam int IMMW = 22;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, out_ready;
    logic            in_ready, out_valid;
    logic [31:0]     in_inst, out_is;
    logic [DW-1:0]   in_rs1_val, in_rs2_val, out_r, out_rs1;
    logic            fwd_ex_valid, fwd_mem_valid;
    logic [4:0]      fwd_ex_rd, fwd_mem_rd;
    logic [DW-1:0]   fwd_ex_val, fwd_mem_val;
    logic [IMMW-1:0] out_imm;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0]   inst;
        logic [DW-1:0] rs1;
        logic [DW-1:0] rs2;
    } entry_t;

    entry_t q[$];

    always #5 clk = ~clk;

    operand_fetch_buffer #(.DW(DW), .IMMW(IMMW)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
        .fwd_ex_valid(fwd_ex_valid), .fwd_ex_rd(fwd_ex_rd), .fwd_ex_val(fwd_ex_val),
        .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_val(fwd_mem_val),
        .out_valid(out_valid), .out_ready(out_ready), .out_is(out_is),
        .out_r(out_r), .out_rs1(out_rs1), .out_imm(out_imm)
    );

    // Architectural operand value seen by a reader of register idx this cycle.
    function automatic logic [DW-1:0] model_val(input logic [4:0] idx, input logic [DW-1:0] v);
`ifdef OPERAND_FWD_EN
        if (idx == 5'd0) return '0;
        if (fwd_ex_valid && fwd_ex_rd == idx) return fwd_ex_val;
        if (fwd_mem_valid && fwd_mem_rd == idx) return fwd_mem_val;
`endif
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; out_ready = 0;
        in_inst = '0; in_rs1_val = '0; in_rs2_val = '0;
        fwd_ex_valid = 0; fwd_ex_rd = '0; fwd_ex_val = '0;
        fwd_mem_valid = 0; fwd_mem_rd = '0; fwd_mem_val = '0;
    endtask

    // Check current outputs against the model, then advance DUT and model one cycle.
    task automatic cycle(input string tag);
        logic   exp_ready, exp_valid, acc, pop;
        entry_t e;
        exp_ready = (q.size() < 2);
        exp_valid = (q.size() > 0);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_ready});
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            chk({tag, ".out_is"}, out_is, q[0].inst);
            chk({tag, ".out_rs1"}, out_rs1, q[0].rs1);
            chk({tag, ".out_r"}, out_r, q[0].rs2);
            chk({tag, ".out_imm"}, {10'd0, out_imm}, {10'd0, q[0].inst[21:0]});
        end
        $display("%s: in_v=%0b acc_exp=%0b pop_exp=%0b flush=%0b out_is=%h out_r=%h depth=%0d",
                 tag, in_valid, in_valid & exp_ready, exp_valid & out_ready, flush,
                 out_is, out_r, q.size());
        acc = in_valid & exp_ready;
        pop = exp_valid & out_ready;
        if (reset || flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
`ifdef OPERAND_FWD_EN
            foreach (q[i]) begin
                q[i].rs1 = model_val(q[i].inst[18:14], q[i].rs1);
                q[i].rs2 = model_val(q[i].inst[4:0], q[i].rs2);
            end
`endif
            if (acc) begin
                e.inst = in_inst;
                e.rs1  = model_val(in_inst[18:14], in_rs1_val);
                e.rs2  = model_val(in_inst[4:0], in_rs2_val);
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".out_is"}, out_is, 32'd0);
        chk({tag, ".out_r"}, out_r, 32'd0);
        chk({tag, ".out_rs1"}, out_rs1, 32'd0);
        chk({tag, ".out_imm"}, {10'd0, out_imm}, 32'd0);
    endtask

    task automatic push(input logic [31:0] inst, input logic [DW-1:0] r1, input logic [DW-1:0] r2);
        in_valid = 1; in_inst = inst; in_rs1_val = r1; in_rs2_val = r2;
    endtask

    initial begin
        logic [31:0] ri;
        idle_inputs();
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        q.delete();
        check_reset_outputs("reset");
        cycle("idle");
        check_reset_outputs("idle_after_reset");

        // Single add instruction, immediately consumed.
        out_ready = 1;
        push(32'h8600_4002, 32'd5, 32'd7);
        cycle("add_push");
        in_valid = 0;
        chk("add.out_is_const", out_is, 32'h8600_4002);
        chk("add.out_rs1_const", out_rs1, 32'd5);
        chk("add.out_r_const", out_r, 32'd7);
        chk("add.out_imm_const", {10'd0, out_imm}, 32'h0000_4002);
        cycle("add_pop");
        cycle("add_empty");

        // Back-to-back A, B, C with a stalled consumer.
        out_ready = 0;
        push(32'h8200_4043, 32'h0A, 32'h0B);
        cycle("A");
        push(32'h8400_8083, 32'h1A, 32'h1B);
        cycle("B");
        push(32'h8800_c0c1, 32'h2A, 32'h2B);
        chk("C.in_ready_low", {31'd0, in_ready}, 32'd0);
        cycle("C_stall");
        out_ready = 1;
        for (int i = 0; i < 5; i++) begin
            if (q.size() == 2 || (i > 0 && i < 2)) in_valid = in_valid;
            cycle("drain_ABC");
            if (i == 1) in_valid = 0;
        end

        // Held operand refreshed by MEM then EX forwarding.
        out_ready = 0;
        push(32'h8600_4002, 32'd5, 32'd7);
        cycle("fwd_hold");
        in_valid = 0;
        fwd_mem_valid = 1; fwd_mem_rd = 5'd2; fwd_mem_val = 32'h11;
        cycle("fwd_mem");
        fwd_ex_valid = 1; fwd_ex_rd = 5'd2; fwd_ex_val = 32'h22;
        fwd_mem_val = 32'h33;
        cycle("fwd_ex_mem");
        fwd_ex_valid = 0; fwd_mem_valid = 0;
        cycle("fwd_after");
        out_ready = 1;
        cycle("fwd_drain");

        // %g0 source with an EX write to r0.
        out_ready = 0;
        fwd_ex_valid = 1; fwd_ex_rd = 5'd0; fwd_ex_val = 32'hFFFF_FFFF;
        push(32'h8600_4000, 32'd9, 32'h1234);
        cycle("g0_push");
        in_valid = 0;
        cycle("g0_hold");
        fwd_ex_valid = 0;
        out_ready = 1;
        cycle("g0_drain");

        // Flush from TWO with simultaneous push and pop.
        out_ready = 0;
        push(32'h8200_4001, 32'd1, 32'd2);
        cycle("fl_a");
        push(32'h8200_4001, 32'd3, 32'd4);
        cycle("fl_b");
        flush = 1; out_ready = 1;
        push(32'h8200_4001, 32'd5, 32'd6);
        cycle("flush");
        flush = 0; in_valid = 0;
        chk("flush.out_valid_low", {31'd0, out_valid}, 32'd0);
        chk("flush.in_ready_high", {31'd0, in_ready}, 32'd1);
        cycle("flush_after");

        // Random traffic over a small register window to provoke forwarding hits.
        for (int n = 0; n < 400; n++) begin
            ri = $urandom;
            ri[18:14] = 5'($urandom_range(0, 3));
            ri[4:0]   = 5'($urandom_range(0, 3));
            in_inst       = ri;
            in_valid      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 2) != 0);
            in_rs1_val    = $urandom;
            in_rs2_val    = $urandom;
            flush         = ($urandom_range(0, 29) == 0);
            fwd_ex_valid  = $urandom_range(0, 1) == 1;
            fwd_ex_rd     = 5'($urandom_range(0, 3));
            fwd_ex_val    = $urandom;
            fwd_mem_valid = $urandom_range(0, 1) == 1;
            fwd_mem_rd    = 5'($urandom_range(0, 3));
            fwd_mem_val   = $urandom;
            reset         = (n == 200);
            cycle("rand");
            if (n == 200) begin
                reset = 0;
                check_reset_outputs("rand_reset");
            end
        end

        idle_inputs();
        reset = 0;
        cycle("final");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/operand_fetch_buffer.md
Name: operand_fetch_buffer

Overview:
- Decode-to-execute pipeline stage for the SPARC V8 datapath. It is the upstream producer for the operand2 source handler.
- Captures the instruction word and the register-file read values, extracts the immediate field, and applies EX/MEM result forwarding.
- Presents the instruction word (IS), the rs2 value (R), the rs1 value and Imm to the execute stage through a valid/ready handshake.
- A 2-entry skid buffer decouples the decoder from execute-stage stalls without losing instructions.

Parameters:
- DW, 32, datapath/register width
- IMMW, 22, width of the extracted immediate field (inst[21:0])

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  synchronous pipeline flush (branch/trap)
- in_valid  in  1  decoder presents an instruction
- in_ready  out  1  buffer can accept this cycle
- in_inst  in  32  instruction word
- in_rs1_val  in  DW  register-file value for inst[18:14]
- in_rs2_val  in  DW  register-file value for inst[4:0]
- fwd_ex_valid  in  1  EX stage writes a register
- fwd_ex_rd  in  5  EX destination register
- fwd_ex_val  in  DW  EX result
- fwd_mem_valid  in  1  MEM stage writes a register
- fwd_mem_rd  in  5  MEM destination register
- fwd_mem_val  in  DW  MEM result
- out_valid  out  1  head entry valid
- out_ready  in  1  execute stage consumes the head entry
- out_is  out  32  head instruction word
- out_r  out  DW  head rs2 value (feeds the operand2 handler)
- out_rs1  out  DW  head rs1 value
- out_imm  out  IMMW  head inst[21:0]

Behaviour:
- Storage: head register H and skid register S, each holding {inst, rs1, rs2}.
- States:
  - EMPTY: no entries.
  - ONE: H valid.
  - TWO: H and S valid.
- in_ready = (state != TWO). It is a function of the state register only, with no combinational path from out_ready.
- out_valid = (state != EMPTY). out_is, out_r, out_rs1 and out_imm are driven from H.
- Define acc = in_valid & in_ready and pop = out_valid & out_ready.
- Transitions:
  - EMPTY, acc -> ONE; H <= input.
  - ONE, acc & !pop -> TWO; S <= input.
  - ONE, acc & pop -> ONE; H <= input.
  - ONE, !acc & pop -> EMPTY.
  - TWO, pop -> ONE; H <= S. No accept is possible in TWO.
  - All other cases: hold.
- Latency: an accepted instruction appears on out_* the next cycle when the buffer was EMPTY, or when it was ONE with a simultaneous pop. Order is strictly FIFO.
- out_imm = H.inst[21:0], carried unmodified. The consumer takes imm22 for SETHI/branch, [12:0] for simm13 and [4:0] for shift counts. No sign extension is done here.
- Forwarding (feature on): for a source index s, value = 0 if s==0 (%g0), else fwd_ex_val if fwd_ex_valid & fwd_ex_rd==s, else fwd_mem_val if fwd_mem_valid & fwd_mem_rd==s, else the stored/input value. EX has priority over MEM.
  - Applied on capture into H or S, using in_inst fields.
  - Re-applied every cycle to held H and S entries, so a producer completing during a stall updates the held operand.
  - The rs2 index is inst[4:0], used regardless of inst[13]; the consumer ignores R when i=1.
- flush: next state EMPTY. It has priority over acc and pop in the same cycle; the incoming instruction is dropped. in_ready=1 the cycle after.
- reset: state EMPTY; in_ready=1, out_valid=0, out_is/out_r/out_rs1/out_imm = 0. Reset mid-transfer discards all entries.
- Data registers of empty slots are not required to clear, except at reset. Outputs are don't-care while out_valid=0, but the bench checks 0 after reset.

Optional Feature:
- Macro: OPERAND_FWD_EN.
- Defined: forwarding and %g0 zero-forcing as above.
- Undefined: the fwd_* ports remain but are ignored. rs1/rs2 are captured and held exactly as given by the register file, with no per-cycle refresh. Handshake and latency are unchanged.

Test Plan:
- Reset, then idle -> in_ready=1, out_valid=0, out_is=0, out_r=0, out_imm=0.
- in_inst=0x8600_4002 (add, rs1=1, rs2=2), rs1_val=5, rs2_val=7, out_ready=1 -> next cycle out_valid=1, out_is=0x8600_4002, out_rs1=5, out_r=7, out_imm=0x00_4002; empty the following cycle.
- out_ready=0, push three instructions A, B, C back-to-back -> A and B accepted, in_ready=0 on C. Raise out_ready -> A, B, C emerge in order with no loss.
- OPERAND_FWD_EN: hold an instruction with rs2=2, rs2_val=7 and out_ready=0. Pulse fwd_mem_valid rd=2 val=0x11, then fwd_ex_valid rd=2 val=0x22 together with MEM rd=2 -> out_r becomes 0x11, then 0x22 (EX wins).
- rs2=0 with fwd_ex_valid rd=0 val=0xFFFF_FFFF -> out_r=0 when the feature is on; out_r=rs2_val when off.
- State TWO, assert flush with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, no instruction emitted.
